// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search controller slice.
// Holds the geometry and width parameters, the controller state encoding,
// and the helper that folds a candidate position into a linear bank address.
package sad_pkg;

  localparam int FRAME_W   = 64;
  localparam int XW        = 6;
  localparam int YW        = 6;
  localparam int ADDR_W    = 12;
  localparam int SAD_W     = 12;
  localparam int MAX_INFL  = 8;
  localparam int NUM_LANES = 16;
  localparam int INFL_W    = $clog2(MAX_INFL + 1);

  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  // FRAME_W is a power of two, so Y*FRAME_W + X is a shift-and-or.
  function automatic logic [ADDR_W-1:0] sad_addr(input logic [YW-1:0] y,
                                                 input logic [XW-1:0] x);
    return (ADDR_W'(y) << $clog2(FRAME_W)) | ADDR_W'(x);
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Datapath-side bus of the SAD search controller.
//   mem_rd / mem_ready : read request handshake, one candidate per transfer
//   cand_x / cand_y    : candidate position of the pending request
//   address            : linear base address shared by all 16 banks
//   sad_valid / sad_in : in-order block SAD results from the adder tree
// Handshake: a read transfers on a rising clock edge where mem_rd and
// mem_ready are both high; while mem_rd is high and mem_ready is low,
// cand_x, cand_y and address hold their values. sad_valid has no back-pressure.
interface sad_search_ctrl_if;
  import sad_pkg::*;

  logic              mem_rd;
  logic              mem_ready;
  logic [XW-1:0]     cand_x;
  logic [YW-1:0]     cand_y;
  logic [ADDR_W-1:0] address;
  logic              sad_valid;
  logic [SAD_W-1:0]  sad_in;

  modport master (
    output mem_rd, cand_x, cand_y, address,
    input  mem_ready, sad_valid, sad_in
  );

  modport slave (
    input  mem_rd, cand_x, cand_y, address,
    output mem_ready, sad_valid, sad_in
  );

endinterface

// File: rtl/sad_raster_cnt.sv
// Raster-order X/Y position counter over a win_w x win_h window.
//   clear  : synchronous return to (0,0)
//   adv    : step one position; X wraps at win_w-1 and carries into Y,
//            Y wraps at win_h-1 so the counter ends back at (0,0)
//   x, y   : current position
//   x_last : x is the last column; last : (x, y) is the final position
module sad_raster_cnt
  import sad_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          adv,
  input  logic [XW-1:0] win_w,
  input  logic [YW-1:0] win_h,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          x_last,
  output logic          last
);

  logic y_last;

  assign x_last = (x == win_w - XW'(1));
  assign y_last = (y == win_h - YW'(1));
  assign last   = x_last && y_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Start/Done sequencer for the 16-lane SAD datapath.
// Walks a candidate window in raster order issuing one read per candidate,
// pairs in-order SAD results with a second raster counter, and reports the
// minimum-SAD position.
//   clk, reset         : clock, asynchronous active-low reset
//   start, abort       : one-cycle control pulses
//   win_w, win_h       : window size, sampled at start
//   bus                : datapath handshake (see sad_search_ctrl_if)
//   busy, done, err    : status; done and err are one-cycle pulses
//   best_x/y, best_sad : result, updated when done asserts
//   state_dbg          : current FSM state
module sad_search_ctrl
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [XW-1:0]     win_w,
  input  logic [YW-1:0]     win_h,
  sad_search_ctrl_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [XW-1:0]     best_x,
  output logic [YW-1:0]     best_y,
  output logic [SAD_W-1:0]  best_sad,
  output logic              err,
  output state_t            state_dbg
);

  state_t              state_q, state_d;
  logic [XW-1:0]       win_w_q;
  logic [YW-1:0]       win_h_q;
  logic [INFL_W-1:0]   infl_q;
  logic [SAD_W-1:0]    run_sad;
  logic [XW-1:0]       run_x, ret_x;
  logic [YW-1:0]       run_y, ret_y;
  logic                iss_last, iss_x_last, ret_last, ret_x_last;
  logic                start_ok, start_bad, xfer, ret_ok, ret_use;

  assign start_ok  = start && (state_q == IDLE) && (win_w != '0) && (win_h != '0);
  assign start_bad = start && (state_q == IDLE) && ((win_w == '0) || (win_h == '0));
  assign xfer      = bus.mem_rd && bus.mem_ready;
  // A result only counts against an outstanding read; strays raise err.
  assign ret_ok    = bus.sad_valid && (infl_q != '0);
  // Results landing in FLUSH still retire reads but never touch the minimum.
  assign ret_use   = ret_ok && ((state_q == ISSUE) || (state_q == DRAIN));

  sad_raster_cnt u_issue_pos (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (start_ok),
    .adv    (xfer),
    .win_w  (win_w_q),
    .win_h  (win_h_q),
    .x      (bus.cand_x),
    .y      (bus.cand_y),
    .x_last (iss_x_last),
    .last   (iss_last)
  );

  sad_raster_cnt u_return_pos (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (start_ok),
    .adv    (ret_use),
    .win_w  (win_w_q),
    .win_h  (win_h_q),
    .x      (ret_x),
    .y      (ret_y),
    .x_last (ret_x_last),
    .last   (ret_last)
  );

  assign bus.mem_rd  = (state_q == ISSUE) && (infl_q != INFL_W'(MAX_INFL));
  assign bus.address = sad_addr(bus.cand_y, bus.cand_x);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign state_dbg   = state_q;

  // Abort is checked before the last-acceptance exit so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   if (abort) state_d = FLUSH;
               else if (xfer && iss_last) state_d = DRAIN;
      DRAIN:   if (abort) state_d = FLUSH;
               else if (infl_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      FLUSH:   if (infl_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      win_w_q  <= '0;
      win_h_q  <= '0;
      infl_q   <= '0;
      err      <= 1'b0;
      run_sad  <= '0;
      run_x    <= '0;
      run_y    <= '0;
      best_x   <= '0;
      best_y   <= '0;
      best_sad <= '0;
    end else begin
      state_q <= state_d;
      err     <= start_bad || (bus.sad_valid && (infl_q == '0));

      if (start_ok) begin
        win_w_q <= win_w;
        win_h_q <= win_h;
      end

      case ({xfer, ret_ok})
        2'b10:   infl_q <= infl_q + INFL_W'(1);
        2'b01:   infl_q <= infl_q - INFL_W'(1);
        default: infl_q <= infl_q;
      endcase

      // Strict less-than keeps the earliest candidate on ties.
      if (start_ok) begin
        run_sad <= SAD_MAX;
        run_x   <= '0;
        run_y   <= '0;
      end else if (ret_use && (bus.sad_in < run_sad)) begin
        run_sad <= bus.sad_in;
        run_x   <= ret_x;
        run_y   <= ret_y;
      end

      if (state_d == DONE) begin
        best_x   <= run_x;
        best_y   <= run_y;
        best_sad <= run_sad;
      end
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int LAT = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [XW-1:0]    win_w;
  logic [YW-1:0]    win_h;
  logic             busy;
  logic             done;
  logic [XW-1:0]    best_x;
  logic [YW-1:0]    best_y;
  logic [SAD_W-1:0] best_sad;
  logic             err;
  state_t           state_dbg;

  sad_search_ctrl_if bus ();

  sad_search_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .win_w     (win_w),
    .win_h     (win_h),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .best_x    (best_x),
    .best_y    (best_y),
    .best_sad  (best_sad),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [SAD_W-1:0] sad_q[$];    // SAD values returned in order
  logic [SAD_W-1:0] sad_def;     // value used when sad_q is empty
  int               ret_q[$];    // cycle at which each read may return
  bit               hold;        // stalls the datapath model's returns
  int               cyc = 0;
  int               xfer_cnt = 0, ret_cnt = 0, done_cnt = 0, err_cnt = 0;
  int               infl_m = 0, infl_max = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_win(input int w, input int h);
    win_w = XW'(w);
    win_h = YW'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_xfers(input string tag, input int base, input int want);
    int n = 0;
    while ((xfer_cnt - base) < want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(xfer_cnt - base), 32'(want));
  endtask

  // ---------------- datapath model ----------------
  // Runs just after each falling edge: retires one due read per cycle unless
  // held, then records the read that the coming rising edge will accept.
  initial begin
    bus.sad_valid = 1'b0;
    bus.sad_in    = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!hold && ret_q.size() > 0 && ret_q[0] <= cyc) begin
        void'(ret_q.pop_front());
        bus.sad_valid = 1'b1;
        bus.sad_in    = (sad_q.size() > 0) ? sad_q.pop_front() : sad_def;
        ret_cnt++;
        infl_m--;
      end else begin
        bus.sad_valid = 1'b0;
      end
      if (bus.mem_rd && bus.mem_ready) begin
        ret_q.push_back(cyc + LAT);
        xfer_cnt++;
        infl_m++;
        if (infl_m > infl_max) infl_max = infl_m;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int x0, d0, e0, r0;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    win_w = '0;
    win_h = '0;
    bus.mem_ready = 1'b0;
    hold = 1'b0;
    sad_def = '0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_address", 32'(bus.address), 0);
    chk("rst_best_sad", 32'(best_sad), 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: 2x2 window, ties keep the first candidate
    sad_q = '{12'd10, 12'd7, 12'd7, 12'd9};
    bus.mem_ready = 1'b1;
    x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    start_win(2, 2);
    wait_done("t1_done", 60);
    chk("t1_best_x", 32'(best_x), 1);
    chk("t1_best_y", 32'(best_y), 0);
    chk("t1_best_sad", 32'(best_sad), 7);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_xfers", 32'(xfer_cnt - x0), 4);
    chk("t1_no_err", 32'(err_cnt - e0), 0);

    // 2: 4x1 window, mem_ready low for 3 cycles after the 2nd accept
    sad_q = '{12'd5, 12'd3, 12'd8, 12'd1};
    x0 = xfer_cnt;
    start_win(4, 1);
    wait_xfers("t2_two_accepts", x0, 2);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_cand_x", 32'(bus.cand_x), 2);
      chk("t2_hold_address", 32'(bus.address), 2);
      chk("t2_hold_mem_rd", 32'(bus.mem_rd), 1);
      @(negedge clk);
    end
    chk("t2_no_xfer_in_stall", 32'(xfer_cnt - x0), 2);
    bus.mem_ready = 1'b1;
    wait_done("t2_done", 60);
    chk("t2_best_x", 32'(best_x), 3);
    chk("t2_best_sad", 32'(best_sad), 1);
    @(negedge clk);
    chk("t2_xfers", 32'(xfer_cnt - x0), 4);

    // 3: 3x3 window aborted with 2 reads in flight
    hold = 1'b1;
    sad_q = '{12'd0, 12'd0, 12'd0};
    x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    start_win(3, 3);
    wait_xfers("t3_three_accepts", x0, 3);
    bus.mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    chk("t3_in_flight", 32'(infl_m), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_flush", 32'(state_dbg), 32'(FLUSH));
    chk("t3_flush_mem_rd", 32'(bus.mem_rd), 0);
    repeat (3) @(negedge clk);
    chk("t3_busy_while_held", 32'(busy), 1);
    hold = 1'b0;
    wait_idle("t3_idle", 30);
    @(negedge clk);
    chk("t3_no_done", 32'(done_cnt - d0), 0);
    chk("t3_best_x_kept", 32'(best_x), 3);
    chk("t3_best_sad_kept", 32'(best_sad), 1);
    chk("t3_no_err", 32'(err_cnt - e0), 0);
    chk("t3_drained", 32'(infl_m), 0);

    // 4: zero dimension start
    bus.mem_ready = 1'b1;
    start_win(0, 5);
    chk("t4_err", 32'(err), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_mem_rd", 32'(bus.mem_rd), 0);
    @(negedge clk);
    chk("t4_err_clear", 32'(err), 0);
    chk("t4_still_idle", 32'(state_dbg), 32'(IDLE));

    // 5: 16x16 window, saturated SADs, in-flight cap
    hold = 1'b1;
    sad_def = 12'd4095;
    infl_max = 0;
    x0 = xfer_cnt; r0 = ret_cnt;
    start_win(16, 16);
    repeat (14) @(negedge clk);
    chk("t5_capped_mem_rd", 32'(bus.mem_rd), 0);
    chk("t5_capped_xfers", 32'(xfer_cnt - x0), 8);
    hold = 1'b0;
    wait_done("t5_done", 2000);
    chk("t5_best_x", 32'(best_x), 0);
    chk("t5_best_y", 32'(best_y), 0);
    chk("t5_best_sad", 32'(best_sad), 4095);
    @(negedge clk);
    chk("t5_infl_max", 32'(infl_max), 8);
    chk("t5_returns", 32'(ret_cnt - r0), 256);
    chk("t5_xfers", 32'(xfer_cnt - x0), 256);

    // 6: reset mid-ISSUE, then stray results
    hold = 1'b1;
    x0 = xfer_cnt;
    start_win(3, 3);
    wait_xfers("t6_two_accepts", x0, 2);
    bus.mem_ready = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("t6_rst_cand_x", 32'(bus.cand_x), 0);
    chk("t6_rst_best_x", 32'(best_x), 0);
    chk("t6_rst_best_sad", 32'(best_sad), 0);
    chk("t6_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    e0 = err_cnt;
    hold = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_stray_err", 32'(err_cnt - e0), 2);
    chk("t6_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
